// File: rtl/key_action_gen_if.sv
// Keycode-in / game-action-out bundle between the USB keycode GPIO and the tetris core.
interface key_action_gen_if;
    logic [31:0] keycode;
    logic        move_left;
    logic        move_right;
    logic        rotate;
    logic        soft_drop;
    logic        hard_drop;
    logic        frame_strobe;

    modport master (
        output keycode,
        input  move_left, move_right, rotate, soft_drop, hard_drop, frame_strobe
    );

    modport slave (
        input  keycode,
        output move_left, move_right, rotate, soft_drop, hard_drop, frame_strobe
    );
endinterface

// File: rtl/key_action_gen.sv
// Converts the HID keycode word into per-frame tetris actions (DAS/ARR shifting, soft-drop repeat, edge rotate/hard drop).
// Optional macro ROLLOVER_FILTER_EN: frames whose report contains ErrorRollOver (8'h01) are ignored.
module key_action_gen #(
    parameter logic [7:0]  KEY_LEFT    = 8'h04,
    parameter logic [7:0]  KEY_RIGHT   = 8'h07,
    parameter logic [7:0]  KEY_ROT     = 8'h1A,
    parameter logic [7:0]  KEY_SOFT    = 8'h16,
    parameter logic [7:0]  KEY_HARD    = 8'h2C,
    parameter int unsigned DAS_DELAY   = 10,
    parameter int unsigned ARR_PERIOD  = 3,
    parameter int unsigned SOFT_PERIOD = 2
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             frame_clk,
    key_action_gen_if.slave  bus
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NSLOT  = 4;
    localparam int unsigned SLOT_W = 8;
    localparam int unsigned NDIR   = 2;

    typedef enum logic [1:0] {H_IDLE, H_DELAY, H_REPEAT} hstate_e;

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [2:0]       fsync_q;
    logic             frame_edge_c;
    logic             strobe_q;

    hstate_e          h_state_q [NDIR];
    hstate_e          h_state_d [NDIR];
    logic [CNT_W-1:0] h_cnt_q   [NDIR];
    logic [CNT_W-1:0] h_cnt_d   [NDIR];
    logic [NDIR-1:0]  h_go_c;
    logic [NDIR-1:0]  h_fire_c;
    logic [CNT_W-1:0] soft_cnt_q, soft_cnt_d;
    logic             soft_fire_c;
    logic             prev_rot_q, prev_hard_q;
    logic             left_held_c, right_held_c, rot_held_c, soft_held_c, hard_held_c;
    logic             report_ok_c;
    logic             left_q, right_q, rot_q, soft_q, hard_q;

    function automatic logic key_held(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (code != 8'h00 && kc[i*SLOT_W +: SLOT_W] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reset asserts immediately, releases on a Clk edge
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // frame_clk: two-flop synchronizer plus edge-history flop
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            fsync_q  <= {fsync_q[1:0], frame_clk};
            strobe_q <= frame_edge_c;
        end
    end
    assign frame_edge_c = fsync_q[1] & ~fsync_q[2];

    assign left_held_c  = key_held(bus.keycode, KEY_LEFT);
    assign right_held_c = key_held(bus.keycode, KEY_RIGHT);
    assign rot_held_c   = key_held(bus.keycode, KEY_ROT);
    assign soft_held_c  = key_held(bus.keycode, KEY_SOFT);
    assign hard_held_c  = key_held(bus.keycode, KEY_HARD);
    // Opposing directions cancel each other out
    assign h_go_c = (left_held_c ^ right_held_c) ? {right_held_c, left_held_c} : 2'b00;

`ifdef ROLLOVER_FILTER_EN
    assign report_ok_c = ~key_held(bus.keycode, 8'h01);
`else
    assign report_ok_c = 1'b1;
`endif

    // Next-state and fire decisions for the horizontal FSMs and soft-drop counter
    always_comb begin
        h_state_d   = h_state_q;
        h_cnt_d     = h_cnt_q;
        h_fire_c    = '0;
        soft_cnt_d  = soft_cnt_q;
        soft_fire_c = 1'b0;

        for (int d = 0; d < NDIR; d++) begin
            if (!h_go_c[d]) begin
                h_state_d[d] = H_IDLE;
                h_cnt_d[d]   = '0;
            end else begin
                case (h_state_q[d])
                    H_IDLE: begin
                        h_fire_c[d]  = 1'b1;
                        h_cnt_d[d]   = CNT_W'(DAS_DELAY);
                        h_state_d[d] = H_DELAY;
                    end
                    H_DELAY, H_REPEAT: begin
                        if (h_cnt_q[d] == CNT_W'(1)) begin
                            h_fire_c[d]  = 1'b1;
                            h_cnt_d[d]   = CNT_W'(ARR_PERIOD);
                            h_state_d[d] = H_REPEAT;
                        end else begin
                            h_cnt_d[d] = h_cnt_q[d] - CNT_W'(1);
                        end
                    end
                    default: begin
                        h_state_d[d] = H_IDLE;
                        h_cnt_d[d]   = '0;
                    end
                endcase
            end
        end

        // Zero count means not held at the last update
        if (!soft_held_c) begin
            soft_cnt_d = '0;
        end else if (soft_cnt_q == '0 || soft_cnt_q == CNT_W'(1)) begin
            soft_fire_c = 1'b1;
            soft_cnt_d  = CNT_W'(SOFT_PERIOD);
        end else begin
            soft_cnt_d = soft_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state_q   <= '{default: H_IDLE};
            h_cnt_q     <= '{default: '0};
            soft_cnt_q  <= '0;
            prev_rot_q  <= 1'b0;
            prev_hard_q <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            rot_q       <= 1'b0;
            soft_q      <= 1'b0;
            hard_q      <= 1'b0;
        end else if (strobe_q) begin
            if (report_ok_c) begin
                h_state_q   <= h_state_d;
                h_cnt_q     <= h_cnt_d;
                soft_cnt_q  <= soft_cnt_d;
                prev_rot_q  <= rot_held_c;
                prev_hard_q <= hard_held_c;
                left_q      <= h_fire_c[0];
                right_q     <= h_fire_c[1];
                rot_q       <= rot_held_c & ~prev_rot_q;
                soft_q      <= soft_fire_c;
                hard_q      <= hard_held_c & ~prev_hard_q;
            end else begin
                left_q  <= 1'b0;
                right_q <= 1'b0;
                rot_q   <= 1'b0;
                soft_q  <= 1'b0;
                hard_q  <= 1'b0;
            end
        end
    end

    assign bus.move_left    = left_q;
    assign bus.move_right   = right_q;
    assign bus.rotate       = rot_q;
    assign bus.soft_drop    = soft_q;
    assign bus.hard_drop    = hard_q;
    assign bus.frame_strobe = strobe_q;

endmodule
